// File: rtl/ce_write_queue.sv
// ce_write_queue: CE generator plus FIFO staging of producer writes onto a CE-gated SDRAM write port
module ce_write_queue #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int CE_DIV   = 4,
    parameter int CE_PHASE = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    input  logic                         clr_overflow,
    output logic                         ce,
    output logic [$clog2(CE_DIV)-1:0]    phase,
    output logic                         out_write,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);
    localparam int PW = $clog2(CE_DIV);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic                     push, pop;

    assign in_ready = level < LW'(DEPTH);
    assign ce       = (phase == PW'(CE_PHASE)) && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = ce && (level != '0);

    // free-running CE phase counter, wraps at CE_DIV-1
    always_ff @(posedge clk) begin
        if (reset) phase <= '0;
        else       phase <= (phase == PW'(CE_DIV-1)) ? '0 : phase + 1'b1;
    end

    // entry storage; contents only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_addr, in_data};
    end

    // pointers and fill level; simultaneous push and pop cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

    // issued write only changes on the edge ending a CE cycle, so it holds a full CE period
    always_ff @(posedge clk) begin
        if (reset) begin
            out_write <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else if (ce) begin
            out_write <= pop;
            if (pop) {out_addr, out_data} <= mem[rd_ptr];
        end
    end

    // sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (reset)                      overflow <= 1'b0;
        else if (in_valid && !in_ready) overflow <= 1'b1;
        else if (clr_overflow)          overflow <= 1'b0;
    end
endmodule
